// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between requester 0 (fetch/branch) and 1 (execute).
// Optional per-requester completion counters are enabled with `define ALU_ARB_PERF_EN.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32
`ifdef ALU_ARB_PERF_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req0_imm,
  input  logic              req0_src,
  input  logic [2:0]        req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [DATA_W-1:0] req1_imm,
  input  logic              req1_src,
  input  logic [2:0]        req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  // shared response
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_zero,
  output logic              rsp_err,
  // ALU side
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_imm,
  output logic              alu_src,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  ops0_cnt,
  output logic [CNT_W-1:0]  ops1_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_t;

  localparam logic [2:0] OP_MAX_LEGAL = 3'b100;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              src_q, src_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  logic              any_valid;
  logic              gnt_sel;
  logic [DATA_W-1:0] sel_a, sel_b, sel_imm;
  logic              sel_src;
  logic [2:0]        sel_op;
  logic              rsp_hs;

  // Contention resolves to the priority pointer; a lone requester wins outright.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    gnt_sel   = (req0_valid && req1_valid) ? prio_q : req1_valid;
    sel_a     = gnt_sel ? req1_a   : req0_a;
    sel_b     = gnt_sel ? req1_b   : req0_b;
    sel_imm   = gnt_sel ? req1_imm : req0_imm;
    sel_src   = gnt_sel ? req1_src : req0_src;
    sel_op    = gnt_sel ? req1_op  : req0_op;
  end

  always_comb begin
    req0_ready = (state_q == ST_IDLE) && any_valid && !gnt_sel;
    req1_ready = (state_q == ST_IDLE) && any_valid &&  gnt_sel;
    rsp0_valid = (state_q == ST_RESP) && !owner_q;
    rsp1_valid = (state_q == ST_RESP) &&  owner_q;
    rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    src_d   = src_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          owner_d = gnt_sel;
          prio_d  = ~gnt_sel;
          a_d     = sel_a;
          b_d     = sel_b;
          imm_d   = sel_imm;
          src_d   = sel_src;
          op_d    = sel_op;
          if (sel_op > OP_MAX_LEGAL) begin
            // Illegal ops bypass the ALU and answer immediately with an error.
            res_d   = '0;
            zero_d  = 1'b0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        res_d   = alu_res;
        zero_d  = alu_zero;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      src_q   <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      src_q   <= src_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_imm  = imm_q;
  assign alu_src  = src_q;
  assign alu_op   = op_q;
  assign rsp_res  = res_q;
  assign rsp_zero = zero_q;
  assign rsp_err  = err_q;

`ifdef ALU_ARB_PERF_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (rsp0_valid && rsp0_ready && (cnt0_q != '1)) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
    if (rsp1_valid && rsp1_ready && (cnt1_q != '1)) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign ops0_cnt = cnt0_q;
  assign ops1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU; counter checks compile in with ALU_ARB_PERF_EN.
module tb_alu_arbiter;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req0_src, rsp0_valid, rsp0_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req0_imm;
  logic [2:0]        req0_op;
  logic              req1_valid, req1_ready, req1_src, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] req1_a, req1_b, req1_imm;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] rsp_res;
  logic              rsp_zero, rsp_err;
  logic [DATA_W-1:0] alu_a, alu_b, alu_imm, alu_res;
  logic              alu_src, alu_zero;
  logic [2:0]        alu_op;
`ifdef ALU_ARB_PERF_EN
  logic [15:0]       ops0_cnt, ops1_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_imm(req0_imm), .req0_src(req0_src), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_imm(req1_imm), .req1_src(req1_src), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_src(alu_src), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero)
`ifdef ALU_ARB_PERF_EN
    , .ops0_cnt(ops0_cnt), .ops1_cnt(ops1_cnt)
`endif
  );

  // Behavioural stand-in for the external combinational ALU.
  logic [DATA_W-1:0] alu_opnd;
  always_comb begin
    alu_opnd = alu_src ? alu_imm : alu_b;
    case (alu_op)
      3'b000:  alu_res = alu_a + alu_opnd;
      3'b001:  alu_res = alu_a - alu_opnd;
      3'b010:  alu_res = alu_a ^ alu_opnd;
      3'b011:  alu_res = ~(alu_a | alu_opnd);
      3'b100:  alu_res = alu_a | alu_opnd;
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_imm = '0; req0_src = 0; req0_op = '0; rsp0_ready = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_imm = '0; req1_src = 0; req1_op = '0; rsp1_ready = 0;
    tick(); tick();
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_res", rsp_res, 0);
    chk("rst_zero", rsp_zero, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    rst = 1'b0;

    // add 5+7 from requester 0
    req0_a = 5; req0_b = 7; req0_imm = 100; req0_src = 0; req0_op = 3'b000; req0_valid = 1;
    rsp0_ready = 1;
    #1;
    chk("add_req0_ready", req0_ready, 1);
    chk("add_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("add_issue_rsp0_valid", rsp0_valid, 0);
    chk("add_issue_req0_ready", req0_ready, 0);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 7);
    chk("add_alu_src", alu_src, 0);
    tick();
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_rsp1_valid", rsp1_valid, 0);
    chk("add_res", rsp_res, 12);
    chk("add_zero", rsp_zero, 0);
    chk("add_err", rsp_err, 0);
    tick();
    chk("add_done_rsp0_valid", rsp0_valid, 0);

    // sub 9-imm(9) from requester 1, response stalled 5 cycles
    req1_a = 9; req1_b = 3; req1_imm = 9; req1_src = 1; req1_op = 3'b001; req1_valid = 1;
    rsp1_ready = 0;
    #1;
    chk("sub_req1_ready", req1_ready, 1);
    chk("sub_req0_ready", req0_ready, 0);
    tick();
    req1_valid = 0;
    req0_a = 1; req0_b = 2; req0_imm = 0; req0_src = 0; req0_op = 3'b000; req0_valid = 1;
    #1;
    chk("sub_issue_req0_ready", req0_ready, 0);
    tick();
    chk("sub_rsp1_valid", rsp1_valid, 1);
    chk("sub_rsp0_valid", rsp0_valid, 0);
    chk("sub_res", rsp_res, 0);
    chk("sub_zero", rsp_zero, 1);
    chk("sub_err", rsp_err, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rsp1_valid", rsp1_valid, 1);
      chk("stall_res", rsp_res, 0);
      chk("stall_zero", rsp_zero, 1);
      chk("stall_req0_ready", req0_ready, 0);
    end
    rsp1_ready = 1;
    #1;
    chk("release_no_grant", req0_ready, 0);
    tick();
    chk("release_rsp1_valid", rsp1_valid, 0);

    // both requesters valid: grants alternate starting with requester 0
    req1_a = 20; req1_b = 5; req1_imm = 0; req1_src = 0; req1_op = 3'b001; req1_valid = 1;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    chk("rr0_req0_ready", req0_ready, 1);
    chk("rr0_req1_ready", req1_ready, 0);
    tick(); tick();
    chk("rr0_rsp0_valid", rsp0_valid, 1);
    chk("rr0_rsp1_valid", rsp1_valid, 0);
    chk("rr0_res", rsp_res, 3);
    req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 3'b010;
    tick();
    chk("rr1_req1_ready", req1_ready, 1);
    chk("rr1_req0_ready", req0_ready, 0);
    tick(); tick();
    chk("rr1_rsp1_valid", rsp1_valid, 1);
    chk("rr1_rsp0_valid", rsp0_valid, 0);
    chk("rr1_res", rsp_res, 15);
    req1_a = 0; req1_b = 0; req1_op = 3'b011;
    tick();
    chk("rr2_req0_ready", req0_ready, 1);
    chk("rr2_req1_ready", req1_ready, 0);
    tick(); tick();
    chk("rr2_rsp0_valid", rsp0_valid, 1);
    chk("rr2_res", rsp_res, 32'hCC);
    chk("rr2_zero", rsp_zero, 0);
    req0_valid = 0;
    tick();
    chk("rr3_req1_ready", req1_ready, 1);
    tick(); tick();
    chk("rr3_rsp1_valid", rsp1_valid, 1);
    chk("rr3_res", rsp_res, 32'hFFFF_FFFF);
    req1_valid = 0;
    tick();
`ifdef ALU_ARB_PERF_EN
    chk("cnt0_after_rr", ops0_cnt, 3);
    chk("cnt1_after_rr", ops1_cnt, 3);
`endif

    // illegal op: response after a single edge with err set
    req0_a = 5; req0_b = 7; req0_src = 0; req0_op = 3'b110; req0_valid = 1;
    #1;
    chk("ill_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    chk("ill_rsp0_valid", rsp0_valid, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_res", rsp_res, 0);
    chk("ill_zero", rsp_zero, 0);
    tick();
    chk("ill_done_rsp0_valid", rsp0_valid, 0);

    // add wraps modulo 2^32
    req0_a = 32'hFFFF_FFFF; req0_b = 7; req0_imm = 1; req0_src = 1; req0_op = 3'b000; req0_valid = 1;
    tick();
    req0_valid = 0;
    chk("wrap_issue_rsp0_valid", rsp0_valid, 0);
    tick();
    chk("wrap_rsp0_valid", rsp0_valid, 1);
    chk("wrap_res", rsp_res, 0);
    chk("wrap_zero", rsp_zero, 1);
    chk("wrap_err", rsp_err, 0);
    tick();
`ifdef ALU_ARB_PERF_EN
    chk("cnt0_after_ill", ops0_cnt, 5);
    chk("cnt1_after_ill", ops1_cnt, 3);
`endif

    // reset while an op is in ISSUE
    req1_a = 32'h10; req1_b = 0; req1_imm = 1; req1_src = 1; req1_op = 3'b100; req1_valid = 1;
    tick();
    req1_valid = 0;
    chk("mid_alu_src", alu_src, 1);
    chk("mid_alu_imm", alu_imm, 1);
    chk("mid_alu_op", alu_op, 4);
    rst = 1;
    tick();
    chk("mid_rst_rsp1_valid", rsp1_valid, 0);
    chk("mid_rst_rsp0_valid", rsp0_valid, 0);
    chk("mid_rst_res", rsp_res, 0);
    chk("mid_rst_err", rsp_err, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_imm", alu_imm, 0);
    chk("mid_rst_alu_src", alu_src, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    chk("mid_rst_req1_ready", req1_ready, 0);
`ifdef ALU_ARB_PERF_EN
    chk("mid_rst_cnt0", ops0_cnt, 0);
    chk("mid_rst_cnt1", ops1_cnt, 0);
`endif
    rst = 0;
    tick();
    chk("post_rst_rsp1_valid", rsp1_valid, 0);

    // first op after reset: or 0x10|imm(1)
    req1_valid = 1;
    #1;
    chk("post_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    chk("post_rsp1_valid", rsp1_valid, 1);
    chk("post_res", rsp_res, 32'h11);
    chk("post_zero", rsp_zero, 0);
    tick();
`ifdef ALU_ARB_PERF_EN
    chk("post_cnt1", ops1_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
